// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed six-digit seven-segment driver for the digital clock.
//   Lights one digit per scan slot. All six BCD inputs are captured into a
//   shadow register once per frame, so a frame never shows a mix of old and
//   new digits. Also handles blinking for time-set, hour leading-zero
//   blanking, a '-' glyph for non-BCD values, and colon dots.
//
// Parameters
//   SCAN_DIV        CP cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1: Seg/Dp/An drive 0 to light/select; 0: active-high
//   BLANK_LEAD      1: blank the hr_hi digit when it is 0
//
// Ports
//   CP          in   system clock (posedge)
//   reset       in   synchronous, active-high reset
//   EN          in   scan/display enable
//   sec_lo..hr_hi in BCD digits 0 (rightmost) .. 5
//   blink_mask  in   bit i set: digit i blinks
//   blink_tick  in   one-cycle pulse that toggles the blink phase
//   Seg         out  segments, Seg[6]=a .. Seg[0]=g
//   Dp          out  decimal point of the selected digit
//   An          out  digit select, An[i] selects digit i (one-hot or none)
module seg7_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEAD     = 1
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic [3:0] sec_lo,
  input  logic [3:0] sec_hi,
  input  logic [3:0] min_lo,
  input  logic [3:0] min_hi,
  input  logic [3:0] hr_lo,
  input  logic [3:0] hr_hi,
  input  logic [5:0] blink_mask,
  input  logic       blink_tick,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [5:0] An
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;

  logic          step;
  logic [3:0]    cur_digit;
  logic [5:0]    cur_sel;
  logic          cur_blink;
  logic          cur_dp;
  logic          blank;

  // Active-high glyph, abcdefg order; non-BCD values show '-'.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = 7'b0000001;
    endcase
    return g;
  endfunction

  assign step = EN && (presc_q == PRESC_LAST);

  // Scan counters, blink phase and frame snapshot.
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    if (EN) begin
      if (step) begin
        presc_d = '0;
        if (idx_q == 3'd5) begin
          idx_d    = '0;
          shadow_d = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (blink_tick) begin
        phase_d = ~phase_q;
      end
    end
  end

  // Digit currently being scanned, taken from the shadow copy only.
  always_comb begin
    cur_digit = shadow_q[3:0];
    cur_sel   = 6'b000001;
    cur_blink = blink_mask[0];
    cur_dp    = 1'b0;
    case (idx_q)
      3'd0: begin cur_digit = shadow_q[3:0];   cur_sel = 6'b000001; cur_blink = blink_mask[0]; end
      3'd1: begin cur_digit = shadow_q[7:4];   cur_sel = 6'b000010; cur_blink = blink_mask[1]; end
      3'd2: begin cur_digit = shadow_q[11:8];  cur_sel = 6'b000100; cur_blink = blink_mask[2]; cur_dp = 1'b1; end
      3'd3: begin cur_digit = shadow_q[15:12]; cur_sel = 6'b001000; cur_blink = blink_mask[3]; end
      3'd4: begin cur_digit = shadow_q[19:16]; cur_sel = 6'b010000; cur_blink = blink_mask[4]; cur_dp = 1'b1; end
      3'd5: begin cur_digit = shadow_q[23:20]; cur_sel = 6'b100000; cur_blink = blink_mask[5]; end
      default: begin
        cur_digit = shadow_q[3:0];
        cur_sel   = 6'b000000;
        cur_blink = 1'b0;
      end
    endcase
  end

  assign blank = (cur_blink && phase_q) ||
                 ((BLANK_LEAD != 0) && (idx_q == 3'd5) && (shadow_q[23:20] == 4'd0));

  // Output stage holds the active-high picture; polarity is applied at the pins.
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (EN && !blank) begin
      seg_d = decode(cur_digit);
      dp_d  = cur_dp;
      an_d  = cur_sel;
    end
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      an_q     <= '0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign Seg = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign Dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign An  = (SEG_ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;

  logic       CP = 1'b0;
  logic       reset = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] dig [6];
  logic [5:0] blink_mask = '0;
  logic       blink_tick = 1'b0;
  logic [6:0] Seg;
  logic       Dp;
  logic [5:0] An;

  always #5 CP = ~CP;

  seg7_scan_driver #(
    .SCAN_DIV(DIV),
    .SEG_ACTIVE_LOW(1),
    .BLANK_LEAD(1)
  ) dut (
    .CP(CP),
    .reset(reset),
    .EN(EN),
    .sec_lo(dig[0]),
    .sec_hi(dig[1]),
    .min_lo(dig[2]),
    .min_hi(dig[3]),
    .hr_lo(dig[4]),
    .hr_hi(dig[5]),
    .blink_mask(blink_mask),
    .blink_tick(blink_tick),
    .Seg(Seg),
    .Dp(Dp),
    .An(An)
  );

  // Expected pin values {An, Seg, Dp}, active-low.
  logic [13:0] exp_q [$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: time measured in enabled cycles since reset.
  int         m_ticks;
  int         m_toggles;
  logic [3:0] m_shadow [6];
  logic [6:0] glyph [16];

  initial begin
    glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
    glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
    glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
    glyph[9] = 7'b1111011;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b0000001;
  end

  // Expected output after the coming edge, then advance the model.
  task automatic model_step();
    int d;
    logic [5:0] an;
    logic [6:0] seg;
    logic dp;
    an = '1; seg = '1; dp = 1'b1;
    if (!reset && EN) begin
      d = m_ticks / DIV;
      if (!((blink_mask[d] && (m_toggles % 2 == 1)) || (d == 5 && m_shadow[5] == 0))) begin
        an  = ~(6'b1 << d);
        seg = ~glyph[m_shadow[d]];
        dp  = ~((d == 2) || (d == 4));
      end
    end
    exp_q.push_back({an, seg, dp});
    if (reset) begin
      m_ticks = 0;
      m_toggles = 0;
      for (int i = 0; i < 6; i++) m_shadow[i] = 4'd0;
    end else if (EN) begin
      if (m_ticks == FRAME - 1) begin
        m_ticks = 0;
        for (int i = 0; i < 6; i++) m_shadow[i] = dig[i];
      end else begin
        m_ticks++;
      end
      if (blink_tick) m_toggles++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge CP);
      #1;
      blink_tick = 1'b0;
      cyc++;
    end
  endtask

  task automatic pulse_blink();
    blink_tick = 1'b1;
    run(1);
  endtask

  // Monitor: one DUT output per cycle, compared against the queue head.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge CP);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({An, Seg, Dp} === e) passes++;
        else $display("FAIL out cyc=%0d An=%b/%b Seg=%b/%b Dp=%b/%b (got/exp)",
                      cyc, An, e[13:8], Seg, e[7:1], Dp, e[0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) dig[i] = 4'(i + 1);
    m_ticks = 0;
    m_toggles = 0;
    for (int i = 0; i < 6; i++) m_shadow[i] = 4'd0;
    #1;
    // Reset state
    reset = 1'b1; EN = 1'b0;
    run(3);
    reset = 1'b0; EN = 1'b1;
    // First frame zeros (digit 5 blanked), then 1..6
    run(2 * FRAME + 4);
    // sec_lo changes mid-frame, seen only after the next wrap
    dig[0] = 4'd7;
    run(FRAME + 6);
    // Leading-zero blank, then invalid BCD on hr_hi
    dig[5] = 4'd0;
    run(2 * FRAME);
    dig[5] = 4'hA;
    dig[3] = 4'hF;
    run(2 * FRAME);
    // Blink digits 0 and 1
    blink_mask = 6'b000011;
    pulse_blink();
    run(FRAME + 3);
    pulse_blink();
    run(FRAME);
    blink_mask = '0;
    // Enable low mid-frame, blink tick ignored while disabled
    run(5);
    EN = 1'b0;
    blink_tick = 1'b1;
    run(10);
    EN = 1'b1;
    run(FRAME);
    // Reset mid-frame
    run(7);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(FRAME + 5);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 299) == 0);
      EN         = ($urandom_range(0, 9) != 0);
      blink_tick = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) blink_mask = 6'($urandom);
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 29) == 0) dig[i] = 4'($urandom_range(0, 15));
      run(1);
    end
    reset = 1'b0;
    EN = 1'b1;
    repeat (2) @(negedge CP);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
